// File: rtl/gpio_cfg_loader.sv
// Serial loader for the two GPIO pad-control shift chains. Both chains shift
// in lock-step, one configuration word per pad, MSB first, and a single
// serial_load strobe commits every pad at the end.
module gpio_cfg_loader #(
  parameter int AREA1PADS  = 19,
  parameter int TOTAL_PADS = 38,
  parameter int CFG_BITS   = 13,
  parameter int CLK_DIV    = 2
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                xfer_start,
  output logic                busy,
  output logic                done,
  output logic [5:0]          cfg_addr_1,
  input  logic [CFG_BITS-1:0] cfg_data_1,
  output logic [5:0]          cfg_addr_2,
  input  logic [CFG_BITS-1:0] cfg_data_2,
  output logic                serial_clock,
  output logic                serial_load,
  output logic                serial_data_1,
  output logic                serial_data_2
);

  localparam int A2         = TOTAL_PADS - AREA1PADS;
  localparam int N          = (AREA1PADS > A2) ? AREA1PADS : A2;
  // The shorter chain is padded with zero words at the start so that both
  // chains finish on their entry pad at the same time.
  localparam int PAD1_START = N - AREA1PADS;
  localparam int PAD2_START = N - A2;
  localparam int KW         = $clog2(N + 1);
  localparam int BW         = $clog2(CFG_BITS + 1);
  localparam int DW         = $clog2(CLK_DIV + 1);

  typedef enum logic [2:0] {IDLE, FETCH, SHIFT_LO, SHIFT_HI, LOAD, DONE} state_t;

  state_t              state_reg, state_next;
  logic [KW-1:0]       step_reg, step_next;
  logic [BW-1:0]       bit_reg, bit_next;
  logic [DW-1:0]       div_reg, div_next;
  logic [CFG_BITS-1:0] shift1_reg, shift1_next;
  logic [CFG_BITS-1:0] shift2_reg, shift2_next;
  logic [5:0]          addr1_reg, addr1_next;
  logic [5:0]          addr2_reg, addr2_next;
  logic                busy_reg, busy_next;
  logic                done_reg, done_next;
  logic                sclk_reg, sclk_next;
  logic                load_reg, load_next;
  logic                sd1_reg, sd1_next;
  logic                sd2_reg, sd2_next;
  logic                enter_fetch;
  logic [KW-1:0]       fetch_step;
  logic                div_last;

  assign div_last = (div_reg == DW'(CLK_DIV - 1));

  // Next-state, counters, shift registers and pad addresses.
  always_comb begin
    state_next  = state_reg;
    step_next   = step_reg;
    bit_next    = bit_reg;
    div_next    = div_reg;
    shift1_next = shift1_reg;
    shift2_next = shift2_reg;
    addr1_next  = addr1_reg;
    addr2_next  = addr2_reg;
    enter_fetch = 1'b0;
    fetch_step  = '0;
    case (state_reg)
      IDLE: begin
        if (xfer_start) begin
          state_next  = FETCH;
          step_next   = '0;
          enter_fetch = 1'b1;
          fetch_step  = '0;
        end
      end
      FETCH: begin
        shift1_next = (int'(step_reg) >= PAD1_START) ? cfg_data_1 : '0;
        shift2_next = (int'(step_reg) >= PAD2_START) ? cfg_data_2 : '0;
        bit_next    = BW'(CFG_BITS - 1);
        div_next    = '0;
        state_next  = SHIFT_LO;
      end
      SHIFT_LO: begin
        if (div_last) begin
          div_next   = '0;
          state_next = SHIFT_HI;
        end else begin
          div_next = div_reg + DW'(1);
        end
      end
      SHIFT_HI: begin
        if (div_last) begin
          div_next = '0;
          if (bit_reg != '0) begin
            // Advance to the next bit; it appears on the falling edge.
            bit_next    = bit_reg - BW'(1);
            shift1_next = {shift1_reg[CFG_BITS-2:0], 1'b0};
            shift2_next = {shift2_reg[CFG_BITS-2:0], 1'b0};
            state_next  = SHIFT_LO;
          end else if (step_reg != KW'(N - 1)) begin
            step_next   = step_reg + KW'(1);
            fetch_step  = step_reg + KW'(1);
            enter_fetch = 1'b1;
            state_next  = FETCH;
          end else begin
            state_next = LOAD;
          end
        end else begin
          div_next = div_reg + DW'(1);
        end
      end
      LOAD: begin
        if (div_last) begin
          div_next   = '0;
          state_next = DONE;
        end else begin
          div_next = div_reg + DW'(1);
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    // Addresses are set up one cycle ahead so cfg_data is valid in FETCH.
    // Padding steps leave the address untouched.
    if (enter_fetch) begin
      if (int'(fetch_step) >= PAD1_START)
        addr1_next = 6'(N - 1 - int'(fetch_step));
      if (int'(fetch_step) >= PAD2_START)
        addr2_next = 6'(TOTAL_PADS - N + int'(fetch_step));
    end
  end

  // Output values decoded from the upcoming state so every output is a flop.
  always_comb begin
    busy_next = (state_next != IDLE);
    done_next = (state_next == DONE);
    sclk_next = (state_next == SHIFT_HI);
    load_next = (state_next == LOAD);
    sd1_next  = 1'b0;
    sd2_next  = 1'b0;
    if (state_next == SHIFT_LO || state_next == SHIFT_HI) begin
      sd1_next = shift1_next[CFG_BITS-1];
      sd2_next = shift2_next[CFG_BITS-1];
    end
  end

  // State and output registers; reset aborts any load without latching.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg  <= IDLE;
      step_reg   <= '0;
      bit_reg    <= '0;
      div_reg    <= '0;
      shift1_reg <= '0;
      shift2_reg <= '0;
      addr1_reg  <= '0;
      addr2_reg  <= '0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      sclk_reg   <= 1'b0;
      load_reg   <= 1'b0;
      sd1_reg    <= 1'b0;
      sd2_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      step_reg   <= step_next;
      bit_reg    <= bit_next;
      div_reg    <= div_next;
      shift1_reg <= shift1_next;
      shift2_reg <= shift2_next;
      addr1_reg  <= addr1_next;
      addr2_reg  <= addr2_next;
      busy_reg   <= busy_next;
      done_reg   <= done_next;
      sclk_reg   <= sclk_next;
      load_reg   <= load_next;
      sd1_reg    <= sd1_next;
      sd2_reg    <= sd2_next;
    end
  end

  assign busy          = busy_reg;
  assign done          = done_reg;
  assign cfg_addr_1    = addr1_reg;
  assign cfg_addr_2    = addr2_reg;
  assign serial_clock  = sclk_reg;
  assign serial_load   = load_reg;
  assign serial_data_1 = sd1_reg;
  assign serial_data_2 = sd2_reg;

endmodule
